// File: rtl/regfile_pkg.sv
// Shared widths and types for the register file and its pending-write scoreboard.
package regfile_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_NUM    = 32;
    localparam int unsigned CNT_W      = 2;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    localparam cnt_t CNT_MAX = cnt_t'(3);

    // Write-back bundle handed from storage to the scoreboard.
    typedef struct packed {
        logic      we;
        reg_addr_t addr;
        word_t     data;
    } wb_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register in-flight writer counters, RAW-hazard stall and sticky
// overflow/underflow error flags.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  wb_t       wb_i,
    input  logic      re1_i,
    input  reg_addr_t addr1_i,
    input  logic      re2_i,
    input  reg_addr_t addr2_i,
    input  logic      issue_i,
    input  logic      dst_we_i,
    input  reg_addr_t dst_addr_i,
    output logic      stall_o,
    output logic      err_ovf_o,
    output logic      err_unf_o
);

    cnt_t pend_q [REG_NUM];
    cnt_t pend_d [REG_NUM];
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
    logic stall_c;
    logic wb_hit1, wb_hit2, haz1, haz2;
    logic inc_v, dec_v, inc_hit, dec_hit;

    // A write-back landing this cycle retires one pending writer before the compare.
    always_comb begin
        wb_hit1 = wb_i.we && (wb_i.addr == addr1_i);
        wb_hit2 = wb_i.we && (wb_i.addr == addr2_i);
        haz1    = re1_i && (addr1_i != '0) && (pend_q[addr1_i] > cnt_t'(wb_hit1));
        haz2    = re2_i && (addr2_i != '0) && (pend_q[addr2_i] > cnt_t'(wb_hit2));
        stall_c = haz1 || haz2;
    end

    always_comb begin
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        inc_hit = 1'b0;
        dec_hit = 1'b0;
        inc_v   = issue_i && !stall_c && dst_we_i && (dst_addr_i != '0);
        dec_v   = wb_i.we && (wb_i.addr != '0);
        for (int unsigned r = 1; r < REG_NUM; r++) begin
            inc_hit = inc_v && (dst_addr_i == REG_ADDR_W'(r));
            dec_hit = dec_v && (wb_i.addr == REG_ADDR_W'(r));
            if (inc_hit && dec_hit) begin
                // Decrement of an empty counter is void, so only the increment lands.
                if (pend_q[r] == '0) begin
                    pend_d[r] = cnt_t'(1);
                end
            end else if (inc_hit) begin
                if (pend_q[r] == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d[r] = pend_q[r] + cnt_t'(1);
                end
            end else if (dec_hit) begin
                if (pend_q[r] == '0) begin
                    unf_d = 1'b1;
                end else begin
                    pend_d[r] = pend_q[r] - cnt_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                pend_q[r] <= '0;
            end
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < REG_NUM; r++) begin
                pend_q[r] <= pend_d[r];
            end
            pend_q[0] <= '0;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign stall_o   = stall_c;
    assign err_ovf_o = ovf_q;
    assign err_unf_o = unf_q;

endmodule

// File: rtl/regfile.sv
// 32x32 register file with same-cycle write-back bypass; hazard tracking
// lives in regfile_scoreboard.
module regfile
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [WORD_WIDTH-1:0] wb_data,
    input  logic                  id_re1,
    input  logic                  id_re2,
    input  logic [REG_ADDR_W-1:0] id_addr1,
    input  logic [REG_ADDR_W-1:0] id_addr2,
    output logic [WORD_WIDTH-1:0] id_data1,
    output logic [WORD_WIDTH-1:0] id_data2,
    input  logic                  id_issue,
    input  logic                  id_dst_we,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    output logic                  stall,
    output logic                  err_ovf,
    output logic                  err_unf
);

    word_t regs_q [REG_NUM];
    wb_t   wb;

    assign wb = '{we: wb_we, addr: wb_addr, data: wb_data};

    function automatic word_t rd_port(logic re, reg_addr_t addr, word_t stored, wb_t w);
        word_t val;
        val = stored;
        if (!re || addr == '0) begin
            val = '0;
        end else if (w.we && w.addr == addr) begin
            val = w.data;
        end
        return val;
    endfunction

    always_comb id_data1 = rd_port(id_re1, id_addr1, regs_q[id_addr1], wb);
    always_comb id_data2 = rd_port(id_re2, id_addr2, regs_q[id_addr2], wb);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wb_we && wb_addr != '0) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wb_i       (wb),
        .re1_i      (id_re1),
        .addr1_i    (id_addr1),
        .re2_i      (id_re2),
        .addr2_i    (id_addr2),
        .issue_i    (id_issue),
        .dst_we_i   (id_dst_we),
        .dst_addr_i (id_dst_addr),
        .stall_o    (stall),
        .err_ovf_o  (err_ovf),
        .err_unf_o  (err_unf)
    );

endmodule

// File: tb/tb_regfile.sv
// Table-driven bench for regfile: one vector per cycle, expected outputs queued
// on drive and popped when outputs are sampled mid-cycle.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_re1, id_re2;
    logic [4:0]  id_addr1, id_addr2;
    logic [31:0] id_data1, id_data2;
    logic        id_issue, id_dst_we;
    logic [4:0]  id_dst_addr;
    logic        stall, err_ovf, err_unf;

    typedef struct {
        int unsigned we, wa, wd, re1, a1, re2, a2, iss, dwe, dst;
        int unsigned d1, d2, st, ovf, unf;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    regfile dut (
        .clk         (clk),
        .rst         (rst),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .id_re1      (id_re1),
        .id_re2      (id_re2),
        .id_addr1    (id_addr1),
        .id_addr2    (id_addr2),
        .id_data1    (id_data1),
        .id_data2    (id_data2),
        .id_issue    (id_issue),
        .id_dst_we   (id_dst_we),
        .id_dst_addr (id_dst_addr),
        .stall       (stall),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", name, n_vec, act, expv);
        end
    endtask

    task automatic drive(input vec_t v);
        wb_we       = 1'(v.we);
        wb_addr     = 5'(v.wa);
        wb_data     = 32'(v.wd);
        id_re1      = 1'(v.re1);
        id_addr1    = 5'(v.a1);
        id_re2      = 1'(v.re2);
        id_addr2    = 5'(v.a2);
        id_issue    = 1'(v.iss);
        id_dst_we   = 1'(v.dwe);
        id_dst_addr = 5'(v.dst);
        exp_q.push_back(v);
    endtask

    task automatic sample();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard vec %0d: got empty queue expected entry", n_vec);
        end else begin
            e = exp_q.pop_front();
            chk("id_data1", id_data1, 32'(e.d1));
            chk("id_data2", id_data2, 32'(e.d2));
            chk("stall",    32'(stall),   32'(e.st));
            chk("err_ovf",  32'(err_ovf), 32'(e.ovf));
            chk("err_unf",  32'(err_unf), 32'(e.unf));
        end
        n_vec++;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        sample();
    endtask

    initial begin
        vec_t v;
        rst = 1'b0;
        drive('{0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0});
        #2;
        sample();                                    // values while held in reset
        @(negedge clk);
        rst = 1'b1;

        //         we wa wd            re1 a1 re2 a2  iss dwe dst  d1            d2            st ovf unf
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   0, 0, 0,   0,            0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   1, 1, 5,   0,            0,            0, 0, 0});
        tbl.push_back('{1, 5, 32'hDEADBEEF, 1, 5, 0, 0,   0, 0, 0,   32'hDEADBEEF, 0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            1, 5, 1, 0,   0, 0, 0,   32'hDEADBEEF, 0,            0, 0, 0});
        tbl.push_back('{1, 0, 32'h12345678, 1, 0, 0, 0,   0, 0, 0,   0,            0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   0, 0, 0,   0,            0,            0, 0, 0});
        // RAW hazard on r7
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   1, 1, 7,   0,            0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            0, 5, 1, 7,   0, 0, 0,   0,            0,            1, 0, 0});
        tbl.push_back('{1, 7, 32'hA5A50001, 0, 0, 1, 7,   0, 0, 0,   0,            32'hA5A50001, 0, 0, 0});
        tbl.push_back('{0, 0, 0,            0, 0, 1, 7,   0, 0, 0,   0,            32'hA5A50001, 0, 0, 0});
        // Saturating counter on r9: four issues, four write-backs
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   1, 1, 9,   0,            0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   1, 1, 9,   0,            0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   1, 1, 9,   0,            0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   1, 1, 9,   0,            0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            1, 9, 0, 0,   0, 0, 0,   0,            0,            1, 1, 0});
        tbl.push_back('{1, 9, 1,            1, 9, 0, 0,   0, 0, 0,   1,            0,            1, 1, 0});
        tbl.push_back('{1, 9, 2,            1, 9, 0, 0,   0, 0, 0,   2,            0,            1, 1, 0});
        tbl.push_back('{1, 9, 3,            1, 9, 0, 0,   0, 0, 0,   3,            0,            0, 1, 0});
        tbl.push_back('{0, 0, 0,            1, 9, 0, 0,   0, 0, 0,   3,            0,            0, 1, 0});
        tbl.push_back('{1, 9, 4,            0, 0, 0, 0,   0, 0, 0,   0,            0,            0, 1, 0});
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   0, 0, 0,   0,            0,            0, 1, 1});
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   1, 1, 12,  0,            0,            0, 1, 1});

        foreach (tbl[i]) apply(tbl[i]);

        // Asynchronous reset between edges with r12 pending and both flags set
        @(negedge clk);
        drive('{0,0,0, 1,12,1,5, 0,0,0, 0,32'hDEADBEEF,1,1,1});
        #1;
        sample();
        #2;
        rst = 1'b0;
        exp_q.push_back('{0,0,0, 1,12,1,5, 0,0,0, 0,0,0,0,0});
        #1;
        sample();
        @(negedge clk);
        rst = 1'b1;

        // Simultaneous issue/write-back on r4 (count 1) and r20 (count 0)
        tbl.delete();
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   1, 1, 4,   0,            0,            0, 0, 0});
        tbl.push_back('{1, 4, 32'h44,       0, 0, 0, 0,   1, 1, 4,   0,            0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            1, 4, 0, 0,   0, 0, 0,   32'h44,       0,            1, 0, 0});
        tbl.push_back('{1, 4, 32'h45,       1, 4, 0, 0,   0, 0, 0,   32'h45,       0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            1, 4, 0, 0,   0, 0, 0,   32'h45,       0,            0, 0, 0});
        tbl.push_back('{1, 20, 32'h20,      0, 0, 0, 0,   1, 1, 20,  0,            0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            0, 0, 1, 20,  0, 0, 0,   0,            32'h20,       1, 0, 0});
        // Write-back to r12 after reset finds an empty counter
        tbl.push_back('{1, 12, 32'hC,       0, 0, 0, 0,   0, 0, 0,   0,            0,            0, 0, 0});
        tbl.push_back('{0, 0, 0,            0, 0, 0, 0,   0, 0, 0,   0,            0,            0, 0, 1});

        foreach (tbl[i]) apply(tbl[i]);

        v = '{0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0};
        @(negedge clk);
        drive(v);
        if (exp_q.size() != 1) begin
            n_bad++;
            $display("FAIL queue_depth vec %0d: got %0d expected 1", n_vec, exp_q.size());
        end
        exp_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
